clock_set_ctrl: RTL

Mode and time-setting controller for the MM:SS digital clock. It takes the raw 1 Hz tick and two raw push-buttons (mode, increment) and produces the enable and increment pulses that sequence the seconds and minutes counters. It also produces a per-digit blank mask for the seven-segment driver, so the field being edited blinks. It sits between the one-second generator and the seconds/minutes counter chain. Integration contract: `sec_inc` and `min_inc` step their field by one modulo 60 and never generate a carry into the next field.

---
 rtl/clock_ctrl_pkg.sv | 53 +++++
 rtl/btn_debounce.sv | 68 ++++++
 rtl/clock_set_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the MM:SS clock mode/time-setting controller.
// Holds the controller mode encoding, default timing constants, the
// per-digit blank masks and small constant helpers used by the RTL.
package clock_ctrl_pkg;

    // Controller mode; 2'b11 is unused and treated as illegal.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10
    } clk_mode_t;

    // Defaults sized for a 100 MHz system clock.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_BLINK_CYCLES    = 25_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    // Blank masks: [3:2] minutes digits, [1:0] seconds digits, 1 = dark.
    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_MIN  = 4'b1100;
    localparam logic [3:0] BLANK_SEC  = 4'b0011;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Digits to darken for a given mode and blink phase (phase 1 = dark).
    function automatic logic [3:0] blank_mask(input clk_mode_t m, input logic phase);
        logic [3:0] mask;
        mask = BLANK_NONE;
        case (m)
            SET_MIN: mask = phase ? BLANK_MIN : BLANK_NONE;
            SET_SEC: mask = phase ? BLANK_SEC : BLANK_NONE;
            default: mask = BLANK_NONE;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and a
// registered rising-edge detector.
// Ports:
//   clk, clr : clock, asynchronous active-high reset (button seen as released)
//   raw      : asynchronous button input
//   level    : debounced button level
//   press    : one-cycle pulse on each accepted rising edge of level
module btn_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-stage synchronizer for the asynchronous button.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, the last disagreeing one flips it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
            level <= 1'b0;
        end else if (sync2_r == level) begin
            cnt_r <= {CNT_W{1'b0}};
            level <= level;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            level <= sync2_r;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            level <= level;
        end
    end

    // Registered rising-edge detector on the debounced level.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            level_d_r <= 1'b0;
            press     <= 1'b0;
        end else begin
            level_d_r <= level;
            press     <= level & ~level_d_r;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode and time-setting controller for the MM:SS clock.
// Sequences RUN -> SET_MIN -> SET_SEC -> RUN on mode presses, gates the 1 Hz
// tick while editing, turns increment presses (with auto-repeat) into
// field-step pulses and blinks the digits of the field being edited.
// Ports:
//   clk, clr  : clock, asynchronous active-high reset
//   tick_1s   : one-cycle 1 Hz pulse
//   btn_mode  : raw mode button
//   btn_inc   : raw increment button
//   run_tick  : tick_1s delayed one cycle, only in RUN
//   sec_inc   : seconds +1 pulse (SET_SEC)
//   min_inc   : minutes +1 pulse (SET_MIN)
//   blank     : per-digit blank, [3:2] minutes, [1:0] seconds, 1 = dark
//   mode      : current mode encoding
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int BLINK_CYCLES    = DEF_BLINK_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_tick,
    output logic       sec_inc,
    output logic       min_inc,
    output logic [3:0] blank,
    output logic [1:0] mode
);

    localparam int RPT_W   = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam int BLINK_W = cnt_width(BLINK_CYCLES);
    // Down-counter reloads: a pulse fires when the counter reaches zero.
    localparam logic [RPT_W-1:0]   RPT_DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]   RPT_PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST      = BLINK_W'(BLINK_CYCLES - 1);

    logic mode_level_unused_s;
    logic mode_press_s;
    logic inc_level_s;
    logic inc_press_s;

    clk_mode_t state_r;
    clk_mode_t state_next_s;

    logic               set_state_s;
    logic               inc_first_s;
    logic               rpt_hold_s;
    logic               rpt_fire_s;
    logic               inc_fire_s;
    logic               rpt_active_r;
    logic               rpt_active_next_s;
    logic [RPT_W-1:0]   rpt_cnt_r;
    logic [RPT_W-1:0]   rpt_cnt_next_s;

    logic               blink_clr_s;
    logic               phase_r;
    logic               phase_next_s;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic [BLINK_W-1:0] blink_cnt_next_s;

    logic       run_tick_r;
    logic       sec_inc_r;
    logic       min_inc_r;
    logic [3:0] blank_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_mode),
        .level (mode_level_unused_s),
        .press (mode_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_inc),
        .level (inc_level_s),
        .press (inc_press_s)
    );

    // Next mode: each mode press advances the cycle; 2'b11 recovers to RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (mode_press_s) state_next_s = SET_MIN;
                else              state_next_s = RUN;
            end
            SET_MIN: begin
                if (mode_press_s) state_next_s = SET_SEC;
                else              state_next_s = SET_MIN;
            end
            SET_SEC: begin
                if (mode_press_s) state_next_s = RUN;
                else              state_next_s = SET_SEC;
            end
            default: state_next_s = RUN;
        endcase
    end

    // Increment pulses and auto-repeat; a mode press wins over any increment.
    always_comb begin
        set_state_s       = (state_r == SET_MIN) || (state_r == SET_SEC);
        inc_first_s       = inc_press_s & ~mode_press_s & set_state_s;
        rpt_hold_s        = rpt_active_r & inc_level_s & ~mode_press_s & set_state_s;
        rpt_fire_s        = rpt_hold_s & (rpt_cnt_r == {RPT_W{1'b0}});
        inc_fire_s        = inc_first_s | rpt_fire_s;
        rpt_active_next_s = 1'b0;
        rpt_cnt_next_s    = {RPT_W{1'b0}};
        if (inc_first_s) begin
            rpt_active_next_s = 1'b1;
            rpt_cnt_next_s    = RPT_DELAY_LOAD;
        end else if (rpt_fire_s) begin
            rpt_active_next_s = 1'b1;
            rpt_cnt_next_s    = RPT_PERIOD_LOAD;
        end else if (rpt_hold_s) begin
            rpt_active_next_s = 1'b1;
            rpt_cnt_next_s    = rpt_cnt_r - RPT_W'(1);
        end else begin
            // Released, mode change or not editing: stop until a new press.
            rpt_active_next_s = 1'b0;
            rpt_cnt_next_s    = {RPT_W{1'b0}};
        end
    end

    // Blink phase; restarts visible on any mode change or increment pulse.
    always_comb begin
        blink_clr_s      = (state_next_s != state_r) | inc_fire_s;
        phase_next_s     = phase_r;
        blink_cnt_next_s = blink_cnt_r;
        if (blink_clr_s) begin
            phase_next_s     = 1'b0;
            blink_cnt_next_s = {BLINK_W{1'b0}};
        end else if (blink_cnt_r == BLINK_LAST) begin
            phase_next_s     = ~phase_r;
            blink_cnt_next_s = {BLINK_W{1'b0}};
        end else begin
            phase_next_s     = phase_r;
            blink_cnt_next_s = blink_cnt_r + BLINK_W'(1);
        end
    end

    // State, repeat and blink registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r      <= RUN;
            rpt_active_r <= 1'b0;
            rpt_cnt_r    <= {RPT_W{1'b0}};
            phase_r      <= 1'b0;
            blink_cnt_r  <= {BLINK_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            rpt_active_r <= rpt_active_next_s;
            rpt_cnt_r    <= rpt_cnt_next_s;
            phase_r      <= phase_next_s;
            blink_cnt_r  <= blink_cnt_next_s;
        end
    end

    // Output registers; blank follows the mode and phase being entered so it
    // never lags the mode output.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            run_tick_r <= 1'b0;
            sec_inc_r  <= 1'b0;
            min_inc_r  <= 1'b0;
            blank_r    <= BLANK_NONE;
        end else begin
            // A tick coinciding with the RUN->SET_MIN press is dropped.
            run_tick_r <= tick_1s & (state_r == RUN) & ~mode_press_s;
            sec_inc_r  <= inc_fire_s & (state_r == SET_SEC);
            min_inc_r  <= inc_fire_s & (state_r == SET_MIN);
            blank_r    <= blank_mask(state_next_s, phase_next_s);
        end
    end

    assign run_tick = run_tick_r;
    assign sec_inc  = sec_inc_r;
    assign min_inc  = min_inc_r;
    assign blank    = blank_r;
    assign mode     = state_r;

endmodule
